// File: rtl/ram_ctrl_pkg.sv
// Shared constants and types for the RAM controller request path.
package ram_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic                          rw;
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram_req_queue_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH:0] DEPTH_COUNT = (PTR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = (count == DEPTH_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_req_queue.sv
// Buffers RAM requests and issues them one at a time to the controller,
// returning one registered response (data, ack or timeout error) per command.
module ram_req_queue
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_rw,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_rw,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          ctrl_start,
    output logic                          ctrl_rw,
    output logic [ADDR_WIDTH-1:0]         ctrl_addr,
    output logic [DATA_WIDTH-1:0]         ctrl_wdata,
    input  logic [DATA_WIDTH-1:0]         ctrl_rdata,
    input  logic                          ctrl_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    typedef struct packed {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    issue_state_t           state;
    issue_state_t           state_next;
    logic [TIMER_WIDTH-1:0] timer;
    req_t                   push_req;
    req_t                   head_req;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   issue;
    logic                   done_hit;
    logic                   timeout_hit;

    assign push_req  = '{rw: req_rw, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (issue),
        .pop_data  (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next  = state;
        issue       = 1'b0;
        done_hit    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && (!rsp_valid || rsp_ready)) begin
                    issue      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (ctrl_done) begin
                    done_hit   = 1'b1;
                    state_next = RELEASE;
                end else if (timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (!ctrl_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new response is only created while the slot is known to be free.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer      <= '0;
            ctrl_start <= 1'b0;
            ctrl_rw    <= 1'b0;
            ctrl_addr  <= '0;
            ctrl_wdata <= '0;
            rsp_valid  <= 1'b0;
            rsp_rw     <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (issue) begin
                ctrl_start <= 1'b1;
                ctrl_rw    <= head_req.rw;
                ctrl_addr  <= head_req.addr;
                ctrl_wdata <= head_req.wdata;
                timer      <= '0;
            end
            if (state == ISSUE) begin
                timer <= timer + 1'b1;
            end
            if (done_hit || timeout_hit) begin
                ctrl_start <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_rw     <= ctrl_rw;
                rsp_err    <= timeout_hit;
                rsp_rdata  <= (done_hit && ctrl_rw == RW_READ) ? ctrl_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_req_queue.sv
// Scoreboard bench for ram_req_queue driven against a behavioural controller stub.
module tb_ram_req_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_rw;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       ctrl_start;
    logic       ctrl_rw;
    logic [7:0] ctrl_addr;
    logic [7:0] ctrl_wdata;
    logic [7:0] ctrl_rdata;
    logic       ctrl_done;
    logic       busy;
    logic [2:0] fifo_count;

    typedef struct {
        logic       rw;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] model_mem [256];
    int         tests = 0;
    int         fails = 0;

    ram_req_queue #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (8),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rw     (rsp_rw),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ctrl_start (ctrl_start),
        .ctrl_rw    (ctrl_rw),
        .ctrl_addr  (ctrl_addr),
        .ctrl_wdata (ctrl_wdata),
        .ctrl_rdata (ctrl_rdata),
        .ctrl_done  (ctrl_done),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Controller stub: done after a short latency, optionally held for several cycles.
    logic [7:0] stub_ram [256];
    logic       never_done = 1'b0;
    int         done_hold = 1;
    int         lat_cnt;
    int         hold_cnt;
    logic       served;

    always @(posedge clk) begin
        if (rst) begin
            ctrl_done  <= 1'b0;
            ctrl_rdata <= '0;
            lat_cnt    <= 0;
            hold_cnt   <= 0;
            served     <= 1'b0;
        end else begin
            if (!ctrl_start) served <= 1'b0;
            if (ctrl_done) begin
                if (hold_cnt > 1) hold_cnt <= hold_cnt - 1;
                else ctrl_done <= 1'b0;
            end else if (ctrl_start && !served && !never_done) begin
                if (lat_cnt >= 2) begin
                    ctrl_done <= 1'b1;
                    hold_cnt  <= done_hold;
                    served    <= 1'b1;
                    lat_cnt   <= 0;
                    if (ctrl_rw) stub_ram[ctrl_addr] <= ctrl_wdata;
                    else ctrl_rdata <= stub_ram[ctrl_addr];
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    // ctrl_start activity monitor, sampled on the falling edge.
    logic start_prev = 1'b0;
    int   start_rises = 0;
    int   cur_len = 0;
    int   last_high_len = 0;
    int   start_while_done = 0;

    always @(negedge clk) begin
        start_prev <= ctrl_start;
        if (ctrl_start && !start_prev) begin
            start_rises <= start_rises + 1;
            cur_len     <= 1;
            if (ctrl_done) start_while_done <= start_while_done + 1;
        end else if (ctrl_start) begin
            cur_len <= cur_len + 1;
        end else if (start_prev) begin
            last_high_len <= cur_len;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic will_timeout);
        int   guard;
        rsp_t e;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (!req_ready) begin
            fails++;
            $display("FAIL send_accept: req_ready=%b after %0d cycles, required 1", req_ready, guard);
        end else begin
            e.rw    = rw;
            e.err   = will_timeout;
            e.rdata = (rw || will_timeout) ? 8'h00 : model_mem[addr];
            if (rw && !will_timeout) model_mem[addr] = wdata;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({rsp_valid, rsp_rw, rsp_rdata, rsp_err, ctrl_start, ctrl_rw, ctrl_addr, ctrl_wdata, busy} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rsp_v=%b rsp_rw=%b rdata=%h err=%b start=%b rw=%b addr=%h wdata=%h busy=%b, required all 0",
                     rsp_valid, rsp_rw, rsp_rdata, rsp_err, ctrl_start, ctrl_rw, ctrl_addr, ctrl_wdata, busy);
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_req_ready: got %b, required 1", req_ready);
        end
        tests++;
        if (fifo_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_fifo_count: got %0d, required 0", fifo_count);
        end
    endtask

    task automatic test_round_trip();
        int   rises0;
        int   guard;
        rsp_t e;
        rsp_ready = 1'b1;
        rises0 = start_rises;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 8'h10;
        req_wdata = 8'hAB;
        @(negedge clk);
        req_valid = 1'b0;
        e.rw = 1'b1; e.rdata = 8'h00; e.err = 1'b0;
        exp_q.push_back(e);
        model_mem[8'h10] = 8'hAB;
        tests++;
        if (fifo_count !== 3'd1 || ctrl_start !== 1'b0) begin
            fails++;
            $display("FAIL rt_accept: fifo_count=%0d start=%b, required 1 and 0", fifo_count, ctrl_start);
        end
        @(negedge clk);
        tests++;
        if ({ctrl_start, ctrl_rw, ctrl_addr, ctrl_wdata, fifo_count} !== {1'b1, 1'b1, 8'h10, 8'hAB, 3'd0}) begin
            fails++;
            $display("FAIL rt_issue: start=%b rw=%b addr=%h wdata=%h count=%0d, required 1 1 10 ab 0",
                     ctrl_start, ctrl_rw, ctrl_addr, ctrl_wdata, fifo_count);
        end
        send(1'b0, 8'h10, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            while (!rsp_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            tests++;
            if (!rsp_valid || exp_q.size() == 0) begin
                fails++;
                $display("FAIL rt_rsp[%0d]: rsp_valid=%b queued=%0d, required a response", i, rsp_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if ({rsp_rw, rsp_rdata, rsp_err} !== {e.rw, e.rdata, e.err}) begin
                    fails++;
                    $display("FAIL rt_rsp[%0d]: rw=%b rdata=%h err=%b, required %b %h %b",
                             i, rsp_rw, rsp_rdata, rsp_err, e.rw, e.rdata, e.err);
                end
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (start_rises - rises0 !== 2) begin
            fails++;
            $display("FAIL rt_start_gap: got %0d separate start pulses, required 2", start_rises - rises0);
        end
    endtask

    task automatic test_burst_backpressure();
        int   guard;
        logic stalled_ok;
        rsp_t e;
        rsp_ready = 1'b0;
        send(1'b1, 8'h30, 8'h55, 1'b0);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (!rsp_valid) begin
            fails++;
            $display("FAIL burst_first_rsp: rsp_valid=%b, required 1", rsp_valid);
        end
        send(1'b1, 8'h20, 8'hCD, 1'b0);
        send(1'b1, 8'h21, 8'hEF, 1'b0);
        send(1'b0, 8'h20, 8'h00, 1'b0);
        send(1'b0, 8'h21, 8'h00, 1'b0);
        tests++;
        if (fifo_count !== 3'd4 || req_ready !== 1'b0) begin
            fails++;
            $display("FAIL burst_full: count=%0d req_ready=%b, required 4 and 0", fifo_count, req_ready);
        end
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 8'h10;
        req_wdata = 8'h00;
        e.rw = 1'b0; e.rdata = model_mem[8'h10]; e.err = 1'b0;
        exp_q.push_back(e);
        stalled_ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || fifo_count !== 3'd4) stalled_ok = 1'b0;
        end
        tests++;
        if (stalled_ok !== 1'b1) begin
            fails++;
            $display("FAIL burst_stall: req_ready/count left 0/4 during backpressure (now %b/%0d)", req_ready, fifo_count);
        end
        tests++;
        if ({rsp_valid, rsp_rw, rsp_rdata, rsp_err} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL burst_hold: v=%b rw=%b rdata=%h err=%b, required 1 1 00 0",
                     rsp_valid, rsp_rw, rsp_rdata, rsp_err);
        end
        rsp_ready = 1'b1;
        fork
            begin
                int g;
                g = 0;
                while (!req_ready && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                tests++;
                if (!req_ready) begin
                    fails++;
                    $display("FAIL burst_fifth_accept: req_ready=%b, required 1", req_ready);
                end
                @(negedge clk);
                req_valid = 1'b0;
            end
            begin
                int   g2;
                rsp_t x;
                for (int i = 0; i < 6; i++) begin
                    g2 = 0;
                    while (!rsp_valid && g2 < 100) begin
                        @(negedge clk);
                        g2++;
                    end
                    tests++;
                    if (!rsp_valid || exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL burst_rsp[%0d]: rsp_valid=%b queued=%0d, required a response", i, rsp_valid, exp_q.size());
                    end else begin
                        x = exp_q.pop_front();
                        if ({rsp_rw, rsp_rdata, rsp_err} !== {x.rw, x.rdata, x.err}) begin
                            fails++;
                            $display("FAIL burst_rsp[%0d]: rw=%b rdata=%h err=%b, required %b %h %b",
                                     i, rsp_rw, rsp_rdata, rsp_err, x.rw, x.rdata, x.err);
                        end
                    end
                    @(negedge clk);
                end
            end
        join
    endtask

    task automatic test_timeout();
        int   guard;
        rsp_t e;
        rsp_ready  = 1'b1;
        never_done = 1'b1;
        send(1'b0, 8'h20, 8'h00, 1'b1);
        send(1'b0, 8'h21, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            while (!rsp_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            tests++;
            if (!rsp_valid || exp_q.size() == 0) begin
                fails++;
                $display("FAIL to_rsp[%0d]: rsp_valid=%b queued=%0d, required a response", i, rsp_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if ({rsp_rw, rsp_rdata, rsp_err} !== {e.rw, e.rdata, e.err}) begin
                    fails++;
                    $display("FAIL to_rsp[%0d]: rw=%b rdata=%h err=%b, required %b %h %b",
                             i, rsp_rw, rsp_rdata, rsp_err, e.rw, e.rdata, e.err);
                end
            end
            never_done = 1'b0;
            @(negedge clk);
            if (i == 0) begin
                @(negedge clk);
                tests++;
                if (last_high_len !== 8) begin
                    fails++;
                    $display("FAIL to_start_len: ctrl_start high %0d cycles, required 8", last_high_len);
                end
            end
        end
    endtask

    task automatic test_level_done();
        int   guard;
        int   swd0;
        int   extra;
        rsp_t e;
        rsp_ready = 1'b1;
        done_hold = 3;
        swd0 = start_while_done;
        send(1'b1, 8'h50, 8'h12, 1'b0);
        send(1'b0, 8'h50, 8'h00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            while (!rsp_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            tests++;
            if (!rsp_valid || exp_q.size() == 0) begin
                fails++;
                $display("FAIL lvl_rsp[%0d]: rsp_valid=%b queued=%0d, required a response", i, rsp_valid, exp_q.size());
            end else begin
                e = exp_q.pop_front();
                if ({rsp_rw, rsp_rdata, rsp_err} !== {e.rw, e.rdata, e.err}) begin
                    fails++;
                    $display("FAIL lvl_rsp[%0d]: rw=%b rdata=%h err=%b, required %b %h %b",
                             i, rsp_rw, rsp_rdata, rsp_err, e.rw, e.rdata, e.err);
                end
            end
            @(negedge clk);
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) extra++;
            @(negedge clk);
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL lvl_extra_rsp: %0d cycles of unexpected rsp_valid, required 0", extra);
        end
        tests++;
        if (start_while_done - swd0 !== 0) begin
            fails++;
            $display("FAIL lvl_start_gate: %0d starts while done high, required 0", start_while_done - swd0);
        end
        done_hold = 1;
    endtask

    task automatic test_reset_mid_issue();
        int seen;
        rsp_ready  = 1'b1;
        never_done = 1'b1;
        send(1'b0, 8'h20, 8'h00, 1'b0);
        send(1'b0, 8'h21, 8'h00, 1'b0);
        send(1'b0, 8'h10, 8'h00, 1'b0);
        send(1'b0, 8'h50, 8'h00, 1'b0);
        tests++;
        if (fifo_count !== 3'd3 || ctrl_start !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_setup: count=%0d start=%b, required 3 and 1", fifo_count, ctrl_start);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tests++;
        if ({ctrl_start, fifo_count, rsp_valid, busy} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL rst_mid_clear: start=%b count=%0d rsp_valid=%b busy=%b, required 0 0 0 0",
                     ctrl_start, fifo_count, rsp_valid, busy);
        end
        never_done = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid || ctrl_start) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rst_mid_quiet: %0d cycles with rsp_valid/ctrl_start, required 0", seen);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_round_trip();
        test_burst_backpressure();
        test_timeout();
        test_level_done();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_req_queue.md
Name: ram_req_queue

Overview:
- Upstream command stage for the RAM controller top.
- Accepts read/write requests on a valid/ready interface and buffers them in a small FIFO.
- Issues buffered requests one at a time on the controller's start/rw/address/write_data/done handshake.
- Returns one response per command (read data or write ack), with a timeout error path.

Parameters:
- ADDR_WIDTH, 8, width of request/controller address.
- DATA_WIDTH, 8, width of write/read data.
- FIFO_DEPTH, 4, request buffer entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64, maximum cycles in ISSUE before aborting a command.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept: fifo_count < FIFO_DEPTH.
- req_rw  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  target address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  consumer accepts response.
- rsp_rw  out  1  rw of the completed command.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  command timed out.
- ctrl_start  out  1  to controller start.
- ctrl_rw  out  1  to controller rw.
- ctrl_addr  out  ADDR_WIDTH  to controller address.
- ctrl_wdata  out  DATA_WIDTH  to controller write_data.
- ctrl_rdata  in  DATA_WIDTH  from controller read_data.
- ctrl_done  in  1  from controller done.
- busy  out  1  state != IDLE or FIFO non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, timer 0; req_ready 1 from the first cycle after reset.
- Reset mid-operation: in-flight command and queued entries are dropped with no response; ctrl_start is low after the reset edge.
- Push: occurs on a clock edge with req_valid && req_ready.
  - When full, req_ready is 0 even if a pop happens in the same cycle (no pass-through).
  - Simultaneous push and pop: count unchanged.
- All ctrl_* and rsp_* outputs are registered.
- IDLE -> ISSUE requires FIFO non-empty and response slot free (!rsp_valid, or rsp_valid && rsp_ready in the same cycle).
  - On that edge: pop the head; load ctrl_rw/addr/wdata; ctrl_start=1; timer=0.
  - Minimum latency: request accepted at edge N gives ctrl_start high after edge N+1.
- ISSUE: ctrl_start and ctrl_rw/addr/wdata are held stable. Timer increments each cycle.
  - ctrl_done sampled 1 at an edge: capture rsp_rdata=ctrl_rdata for reads, 0 for writes; rsp_rw=ctrl_rw; rsp_err=0; rsp_valid=1; ctrl_start=0; go to RELEASE.
  - Timer reaches TIMEOUT_CYCLES-1 with no done: rsp_valid=1, rsp_err=1, rsp_rdata=0; ctrl_start=0; go to RELEASE.
  - Done and timeout on the same edge: done wins.
- RELEASE: ctrl_start stays 0. Return to IDLE on the first edge where ctrl_done is sampled 0.
  - ctrl_start is therefore low for at least one cycle between commands, so a level-type done never completes two commands.
- Response: rsp_valid stays high and rsp_* stay stable until the edge with rsp_ready=1, which clears rsp_valid.
  - Only one response is ever outstanding; issue stalls while it is pending.
- Ordering: strict FIFO; responses are returned in request order.

Decomposition:
- Package ram_ctrl_pkg:
  - default ADDR_WIDTH/DATA_WIDTH;
  - RW_READ=0, RW_WRITE=1;
  - state encoding IDLE/ISSUE/RELEASE;
  - packed request struct {rw, addr, wdata}.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH): push/pop/full/empty/count, synchronous reset.
- ram_req_queue holds the issue FSM, timer and response register.

Test Plan:
- Reset: rst high 2 cycles -> all outputs 0, req_ready=1, fifo_count=0.
- Single round trip through the real top: write 0xAB to 0x10, then read 0x10 -> write rsp (rw=1, rdata=0, err=0), then read rsp rdata=0xAB; ctrl_start low at least 1 cycle between the two commands.
- Burst with backpressure: 5 back-to-back requests (writes 0x20=0xCD and 0x21=0xEF, reads 0x20, 0x21, 0x10), rsp_ready=0 for 30 cycles:
  - req_ready drops at 4 queued, so the 5th stalls;
  - after release, responses arrive in order: read data 0xCD, 0xEF, 0xAB.
- Timeout: stub controller never asserts done, TIMEOUT_CYCLES=8 -> rsp_valid with rsp_err=1 after 8 cycles of start; the next queued command then issues normally.
- Level done: stub holds done high 3 cycles after completion -> exactly one response; next start waits for done low.
- Reset mid-ISSUE with 3 queued -> no responses, fifo_count=0, ctrl_start=0 after the reset edge.
